// File: rtl/prog_loader_pkg.sv
// Shared constants, FSM encodings and helpers for the program loader.
package prog_loader_pkg;

    localparam int unsigned BYTES_PER_WORD = 6;
    localparam int unsigned BYTE_WIDTH     = 8;
    localparam int unsigned WORD_WIDTH     = BYTES_PER_WORD * BYTE_WIDTH;
    localparam int unsigned IDX_WIDTH      = 3;
    localparam int unsigned STATE_WIDTH    = 3;

    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_CHECK = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Every state other than IDLE belongs to an active load.
    function automatic logic is_active(input state_t s);
        return s != ST_IDLE;
    endfunction

endpackage

// File: rtl/prog_word_assembler.sv
// Collects little-endian stream bytes into one instruction word, lane 0 first.
module prog_word_assembler
    import prog_loader_pkg::*;
#(
    parameter int unsigned NUM_LANES = BYTES_PER_WORD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic [7:0]              byte_in,
    output logic                    word_complete_c,
    output logic [8*NUM_LANES-1:0]  word_c
);

    logic [8*NUM_LANES-1:0] lanes_q;
    logic [IDX_WIDTH-1:0]   idx_q;

    // word_c already carries the incoming byte so the final lane is usable on its own edge.
    always_comb begin
        word_c = lanes_q;
        for (int k = 0; k < int'(NUM_LANES); k++) begin
            if (idx_q == IDX_WIDTH'(k)) begin
                word_c[8*k +: 8] = byte_in;
            end
        end
    end

    assign word_complete_c = load && (idx_q == IDX_WIDTH'(NUM_LANES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lanes_q <= '0;
            idx_q   <= '0;
        end else if (load) begin
            lanes_q <= word_c;
            idx_q   <= word_complete_c ? '0 : idx_q + IDX_WIDTH'(1);
        end
    end

endmodule

// File: rtl/prog_loader.sv
// Loads a byte stream into program memory as 48-bit words while holding the CPU in reset.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per load.
module prog_loader #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned BYTES_PER_WORD = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [ADDR_WIDTH:0]           word_count,
    input  logic [7:0]                    in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          rom_we,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    output logic [8*BYTES_PER_WORD-1:0]   rom_data,
    output logic                          cpu_hold,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);

    import prog_loader_pkg::*;

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam int unsigned DW = 8 * BYTES_PER_WORD;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam logic [2:0] ST_AFTER_LAST = ST_CHECK;
`else
    localparam logic [2:0] ST_AFTER_LAST = ST_DONE;
`endif

    state_t                state_q, state_d;
    logic [CW-1:0]         count_q;
    logic [ADDR_WIDTH-1:0] word_idx_q;

    logic          fire_c;
    logic          start_ok_c;
    logic          last_word_c;
    logic          asm_load_c;
    logic          asm_complete_c;
    logic [DW-1:0] asm_word_c;

    assign fire_c      = in_valid && in_ready;
    assign start_ok_c  = (state_q == ST_IDLE) && start;
    assign last_word_c = ({1'b0, word_idx_q} == (count_q - CW'(1)));
    assign asm_load_c  = fire_c && (state_q == ST_LOAD);

    prog_word_assembler #(
        .NUM_LANES       (BYTES_PER_WORD)
    ) u_asm (
        .clk             (clk),
        .reset           (reset),
        .clear           (start_ok_c),
        .load            (asm_load_c),
        .byte_in         (in_data),
        .word_complete_c (asm_complete_c),
        .word_c          (asm_word_c)
    );

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (word_count == '0) ? ST_AFTER_LAST : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (asm_complete_c) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = last_word_c ? ST_AFTER_LAST : ST_LOAD;
            end
            ST_CHECK: begin
                if (fire_c) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register; status outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            word_idx_q <= '0;
            in_ready   <= 1'b0;
            rom_we     <= 1'b0;
            rom_addr   <= '0;
            rom_data   <= '0;
            cpu_hold   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state_q  <= state_d;
            in_ready <= (state_d == ST_LOAD) || (state_d == ST_CHECK);
            rom_we   <= (state_d == ST_WRITE);
            cpu_hold <= is_active(state_d);
            busy     <= is_active(state_d);
            done     <= (state_d == ST_DONE);

            if (start_ok_c) begin
                count_q    <= word_count;
                word_idx_q <= '0;
            end else if ((state_q == ST_WRITE) && !last_word_c) begin
                word_idx_q <= word_idx_q + ADDR_WIDTH'(1);
            end

            if (asm_complete_c) begin
                rom_addr <= word_idx_q;
                rom_data <= asm_word_c;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] csum_q;

    // Running XOR over data bytes; the byte received in CHECK is compared against it.
    always_ff @(posedge clk) begin
        if (reset) begin
            csum_q <= '0;
            error  <= 1'b0;
        end else if (start_ok_c) begin
            csum_q <= '0;
            error  <= 1'b0;
        end else if (asm_load_c) begin
            csum_q <= csum_q ^ in_data;
        end else if ((state_q == ST_CHECK) && fire_c && (in_data != csum_q)) begin
            error <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: directed loads, stalls, reset abort, address wrap, checksum.
module tb_prog_loader;

    localparam int unsigned AW = 8;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int DONE_GAP = 2;
`else
    localparam int DONE_GAP = 1;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [47:0]   data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   word_count;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_ready;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [47:0]   rom_data;
    logic          cpu_hold;
    logic          busy;
    logic          done;
    logic          error;

    prog_loader #(
        .ADDR_WIDTH     (AW),
        .BYTES_PER_WORD (6)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .word_count (word_count),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rom_we     (rom_we),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    wr_t           exp_q[$];
    wr_t           mon_e;
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_writes = 0;
    int            n_done = 0;
    int            last_write_cyc = 0;
    int            last_done_cyc = 0;
    int            rdy_bad = 0;
    logic [AW-1:0] last_addr = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        if (rom_we === 1'b1) begin
            n_writes++;
            last_write_cyc = cyc;
            last_addr = rom_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(rom_addr), 64'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", 64'(rom_addr), 64'(mon_e.addr));
                check("wr_data", 64'(rom_data), 64'(mon_e.data));
            end
        end
        if (done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc;
        end
        // Inside a load only the write cycles may drop in_ready.
        if (busy === 1'b1 && done === 1'b0 && in_ready === rom_we) rdy_bad++;
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_load(input int cnt);
        word_count = (AW+1)'(cnt);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap, output int xfer_cyc);
        int k;
        in_valid = 1'b0;
        tick(gap);
        in_data = b;
        in_valid = 1'b1;
        k = 0;
        while (in_ready !== 1'b1 && k < 64) begin
            tick();
            k++;
        end
        xfer_cyc = cyc;
        if (k >= 64) check("in_ready_timeout", 64'd0, 64'd1);
        else tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [47:0] w, input int gap);
        int c;
        for (int l = 0; l < 6; l++) send(w[8*l +: 8], gap, c);
    endtask

    task automatic finish_load(input logic [7:0] csum);
`ifdef PROG_LOADER_CHECKSUM_EN
        int c;
        send(csum, 0, c);
`else
        if (csum === 8'hxx) tick();
`endif
    endtask

    task automatic wait_done(input string name);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        if (k >= 40) begin
            check({name, "_done_timeout"}, 64'd0, 64'd1);
        end else begin
            check({name, "_hold_in_done"}, 64'(cpu_hold), 64'd1);
            tick();
            check({name, "_hold_after"}, 64'(cpu_hold), 64'd0);
            check({name, "_busy_after"}, 64'(busy), 64'd0);
        end
    endtask

    function automatic logic [7:0] xor6(input logic [47:0] w);
        logic [7:0] x;
        x = 8'h00;
        for (int l = 0; l < 6; l++) x = x ^ w[8*l +: 8];
        return x;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int          first_cyc;
        int          c;
        int          w0;
        int          d0;
        logic [7:0]  cs;
        logic [47:0] w;
        int          gaps [12];
        gaps = '{1, 0, 2, 0, 0, 3, 0, 1, 0, 0, 2, 0};

        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; word_count = '0;
        tick(2);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_rom_we",   64'(rom_we),   64'd0);
        check("rst_rom_addr", 64'(rom_addr), 64'd0);
        check("rst_rom_data", 64'(rom_data), 64'd0);
        check("rst_cpu_hold", 64'(cpu_hold), 64'd0);
        check("rst_busy",     64'(busy),     64'd0);
        check("rst_done",     64'(done),     64'd0);
        check("rst_error",    64'(error),    64'd0);
        reset = 1'b0;
        tick();

        // Idle ignores in_valid.
        in_valid = 1'b1; in_data = 8'hEE;
        tick(2);
        check("idle_in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0;

        // Single word, stream held valid.
        exp_q.push_back('{addr: 8'h00, data: 48'h060504030201});
        begin_load(1);
        send(8'h01, 0, first_cyc);
        for (int i = 2; i <= 6; i++) send(8'(i), 0, c);
        finish_load(8'h07);
        wait_done("t1");
        check("t1_latency", 64'(last_write_cyc - first_cyc), 64'd6);
        check("t1_done_gap", 64'(last_done_cyc - last_write_cyc), 64'(DONE_GAP));
        check("t1_error", 64'(error), 64'd0);

        // Two words with stalls; a start while busy must be ignored.
        w0 = n_writes; d0 = n_done; cs = 8'h00;
        exp_q.push_back('{addr: 8'h00, data: 48'h151413121110});
        exp_q.push_back('{addr: 8'h01, data: 48'h1B1A19181716});
        begin_load(2);
        for (int i = 0; i < 12; i++) begin
            send(8'(8'h10 + i), gaps[i], c);
            cs = cs ^ 8'(8'h10 + i);
            if (i == 3) begin
                word_count = 9'd5; start = 1'b1; tick(); start = 1'b0;
            end
        end
        finish_load(cs);
        wait_done("t2");
        check("t2_writes", 64'(n_writes - w0), 64'd2);
        check("t2_dones", 64'(n_done - d0), 64'd1);
        check("t2_ready_gaps", 64'(rdy_bad), 64'd0);
        tick(3);
        check("t2_hold_addr", 64'(rom_addr), 64'h01);
        check("t2_hold_data", 64'(rom_data), 64'h1B1A19181716);

        // Zero-count load.
        w0 = n_writes;
        begin_load(0);
        finish_load(8'h00);
        wait_done("t3");
        check("t3_writes", 64'(n_writes - w0), 64'd0);

        // Reset partway into the second word abandons the load.
        w0 = n_writes;
        exp_q.push_back('{addr: 8'h00, data: 48'h252423222120});
        begin_load(2);
        send_word(48'h252423222120, 0);
        for (int i = 0; i < 3; i++) send(8'(8'h30 + i), 0, c);
        reset = 1'b1;
        tick();
        check("t4_hold_after_rst", 64'(cpu_hold), 64'd0);
        check("t4_busy_after_rst", 64'(busy), 64'd0);
        reset = 1'b0;
        tick(10);
        check("t4_writes", 64'(n_writes - w0), 64'd1);
        check("t4_queue_empty", 64'(exp_q.size()), 64'd0);
        exp_q.push_back('{addr: 8'h00, data: 48'hA6A5A4A3A2A1});
        begin_load(1);
        send_word(48'hA6A5A4A3A2A1, 0);
        finish_load(xor6(48'hA6A5A4A3A2A1));
        wait_done("t4b");

        // Full address range: byte = (addr + lane) & 0xFF.
        w0 = n_writes; d0 = n_done; cs = 8'h00;
        for (int a = 0; a < 256; a++) begin
            for (int l = 0; l < 6; l++) w[8*l +: 8] = 8'(a + l);
            exp_q.push_back('{addr: AW'(a), data: w});
        end
        begin_load(256);
        for (int a = 0; a < 256; a++) begin
            for (int l = 0; l < 6; l++) w[8*l +: 8] = 8'(a + l);
            cs = cs ^ xor6(w);
            send_word(w, 0);
        end
        finish_load(cs);
        wait_done("t5");
        check("t5_writes", 64'(n_writes - w0), 64'd256);
        check("t5_last_addr", 64'(last_addr), 64'hFF);
        check("t5_dones", 64'(n_done - d0), 64'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum sets a sticky error, cleared only by the next start.
        exp_q.push_back('{addr: 8'h00, data: 48'h060504030201});
        begin_load(1);
        send_word(48'h060504030201, 0);
        finish_load(8'h08);
        wait_done("t6");
        check("t6_error_set", 64'(error), 64'd1);
        tick(4);
        check("t6_error_sticky", 64'(error), 64'd1);
        exp_q.push_back('{addr: 8'h00, data: 48'h060504030201});
        begin_load(1);
        check("t6_error_cleared", 64'(error), 64'd0);
        send_word(48'h060504030201, 0);
        finish_load(8'h07);
        wait_done("t6b");
        check("t6b_error", 64'(error), 64'd0);
`else
        check("error_tied_low", 64'(error), 64'd0);
`endif

        tick(2);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        check("ready_gaps_total", 64'(rdy_bad), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
